// File: rtl/rv_stream_mcast_demux.sv
// -----------------------------------------------------------------------------
// rv_stream_mcast_demux
//
// Multi-lane stream demultiplexer with one first-word-fall-through FIFO per
// (destination, lane) pair. Each input lane steers its beat either to a single
// destination (index mode, MCAST=0) or to any subset of destinations (mask
// mode, MCAST=1). A multicast beat is written into every targeted FIFO on the
// same edge or not at all, so consumers never see a partial broadcast.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   sel_in     in   LANES*SELW        per-lane selector, lane j at [j*SELW +: SELW]
//   valid_in   in   LANES             per-lane input valid
//   data_in    in   LANES*DATAW       per-lane payload
//   ready_in   out  LANES             per-lane input ready
//   valid_out  out  NUM_REQS*LANES    output valid, slot i*LANES+j
//   data_out   out  NUM_REQS*LANES*DATAW  output payload (FIFO head)
//   ready_out  in   NUM_REQS*LANES    output ready
//   full_out   out  NUM_REQS*LANES    FIFO (i,j) holds DEPTH entries
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// rv_stream_mcast_demux_fifo
//
// Single FWFT FIFO. DEPTH must be a power of two (>= 2) so the pointers wrap
// naturally. The head entry is visible on `head` whenever `valid` is high.
//
// Ports
//   clk, reset  clock and synchronous active-high reset
//   push        write push_data at the tail (caller guarantees !full)
//   push_data   payload to write
//   pop         consume the head entry (ignored while empty)
//   valid       FIFO holds at least one entry
//   full        FIFO holds DEPTH entries
//   head        current head entry
// -----------------------------------------------------------------------------
module rv_stream_mcast_demux_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [DATAW-1:0] head
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  rd_ptr;
  logic [PTRW-1:0]  wr_ptr;
  logic [CNTW-1:0]  count;
  logic             pop_en;

  // A pop with nothing stored is meaningless; gate it so pointers stay aligned.
  assign pop_en = pop & valid;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop_en})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; valid is derived
  // from count, so stale entries are never observable and the RAM stays plain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign valid = (count != '0);
  assign full  = (count == CNTW'(DEPTH));
  assign head  = mem[rd_ptr];

endmodule

module rv_stream_mcast_demux #(
  parameter  int NUM_REQS     = 2,
  parameter  int LANES        = 1,
  parameter  int DATAW        = 8,
  parameter  int DEPTH        = 4,
  parameter  int MCAST        = 0,
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int SELW         = (MCAST != 0) ? NUM_REQS : LOG_NUM_REQS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [LANES*SELW-1:0]              sel_in,
  input  logic [LANES-1:0]                   valid_in,
  input  logic [LANES*DATAW-1:0]             data_in,
  output logic [LANES-1:0]                   ready_in,
  output logic [NUM_REQS*LANES-1:0]          valid_out,
  output logic [NUM_REQS*LANES*DATAW-1:0]    data_out,
  input  logic [NUM_REQS*LANES-1:0]          ready_out,
  output logic [NUM_REQS*LANES-1:0]          full_out
);

  // Target set per lane, lane-major: bit j*NUM_REQS+i means lane j -> dest i.
  logic [LANES*NUM_REQS-1:0] tgt;
  // Lane j has at least one targeted FIFO that is full.
  logic [LANES-1:0]          blocked;

  // ---------------------------------------------------------------------------
  // Selector decode
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [NUM_REQS-1:0] lane_tgt;

    if (NUM_REQS == 1) begin : g_single
      // Only one destination exists: the selector carries no information.
      assign lane_tgt = 1'b1;
    end else if (MCAST != 0) begin : g_mask
      assign lane_tgt = sel_in[j*SELW +: NUM_REQS];
    end else begin : g_index
      logic [SELW-1:0] lane_sel;
      assign lane_sel = sel_in[j*SELW +: SELW];
      // An index at or above NUM_REQS matches no decoder output, so the beat
      // has an empty target set and is consumed without being stored.
      for (genvar i = 0; i < NUM_REQS; i++) begin : g_dec
        assign lane_tgt[i] = (lane_sel == SELW'(i));
      end
    end

    assign tgt[j*NUM_REQS +: NUM_REQS] = lane_tgt;
  end

  // ---------------------------------------------------------------------------
  // Input flow control
  // ---------------------------------------------------------------------------
  // Readiness looks only at registered fullness, never at ready_out, so a full
  // FIFO refuses a push even when it is being popped in the same cycle. This
  // keeps the consumer-to-producer path free of combinational logic.
  always_comb begin
    // NOTE: defaults first so every path assigns blocked and no latch appears.
    blocked = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (tgt[j*NUM_REQS + i] && full_out[i*LANES + j]) begin
          blocked[j] = 1'b1;
        end
      end
    end
  end

  assign ready_in = {LANES{~reset}} & ~blocked;

  // ---------------------------------------------------------------------------
  // Per (destination, lane) FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_dest
    for (genvar j = 0; j < LANES; j++) begin : g_fifo
      localparam int K = i*LANES + j;

      logic push;
      logic pop;

      // Accept is shared by every targeted FIFO of the lane, which makes a
      // multicast write atomic: either all targets take the beat or none do.
      assign push = valid_in[j] & ready_in[j] & tgt[j*NUM_REQS + i];
      assign pop  = ready_out[K];

      rv_stream_mcast_demux_fifo #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (data_in[j*DATAW +: DATAW]),
        .pop       (pop),
        .valid     (valid_out[K]),
        .full      (full_out[K]),
        .head      (data_out[K*DATAW +: DATAW])
      );
    end
  end

endmodule
